// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer.
// Command word packs addr, rw, data from MSB to LSB.
package i2c_pkg;

    localparam int CMD_W = 16;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NACK    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with natural-wrap pointers
// and an extra count bit to tell full from empty.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host commands and drives them one at a time into the
// single-byte I2C master, with NACK retry and a done timeout.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [6:0] i_cmd_addr,
    input  logic       i_cmd_rw,
    input  logic [7:0] i_cmd_data,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic [1:0] o_rsp_status,
    output logic [6:0] o_Slave_Add,
    output logic       o_RW,
    output logic [7:0] o_DATA,
    output logic       o_start,
    input  logic       i_busy,
    input  logic       i_done,
    input  logic       i_ack_ok,
    input  logic [7:0] i_rd_data
);

    localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TW  = $clog2(TIMEOUT) + 1;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [RTW-1:0]   retry_q, retry_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic             start_q, start_d;

    logic [CMD_W-1:0] fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty, fifo_pop;

    assign fifo_din = {i_cmd_addr, i_cmd_rw, i_cmd_data};

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_cmd_valid),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_cmd_ready  = !fifo_full;
    assign o_rsp_valid  = (state_q == S_RESP);
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_status = rsp_status_q;
    assign o_Slave_Add  = cmd_q.addr;
    assign o_RW         = cmd_q.rw;
    assign o_DATA       = cmd_q.data;
    assign o_start      = start_q;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        start_d      = 1'b0;
        fifo_pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d    = cmd_t'(fifo_dout);
                    fifo_pop = 1'b1;
                    retry_d  = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Busy only counts as acceptance once start was visible.
                start_d = !i_busy;
                if (start_q && i_busy) begin
                    start_d = 1'b0;
                    tmo_d   = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + TW'(1);
                if (i_done) begin
                    if (i_ack_ok) begin
                        rsp_status_d = ST_OK;
                        rsp_data_d   = cmd_q.rw ? i_rd_data : 8'h00;
                        state_d      = S_RESP;
                    end else if (retry_q < RTW'(MAX_RETRY)) begin
                        retry_d = retry_q + RTW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        rsp_status_d = ST_NACK;
                        rsp_data_d   = 8'h00;
                        state_d      = S_RESP;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_data_d   = 8'h00;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            start_q      <= start_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with an in-line
// master model driven from the main stimulus sequence.
module tb_i2c_cmd_sequencer;

    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [6:0] i_cmd_addr = '0;
    logic       i_cmd_rw = 1'b0;
    logic [7:0] i_cmd_data = '0;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b0;
    logic [7:0] o_rsp_data;
    logic [1:0] o_rsp_status;
    logic [6:0] o_Slave_Add;
    logic       o_RW;
    logic [7:0] o_DATA;
    logic       o_start;
    logic       i_busy = 1'b0;
    logic       i_done = 1'b0;
    logic       i_ack_ok = 1'b0;
    logic [7:0] i_rd_data = '0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic start_prev = 1'b0;
    logic [6:0] seen_addr;

    i2c_cmd_sequencer #(
        .DEPTH(4), .MAX_RETRY(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw),
        .i_cmd_data(i_cmd_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status),
        .o_Slave_Add(o_Slave_Add), .o_RW(o_RW), .o_DATA(o_DATA),
        .o_start(o_start), .i_busy(i_busy), .i_done(i_done),
        .i_ack_ok(i_ack_ok), .i_rd_data(i_rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_start && !start_prev) start_cnt <= start_cnt + 1;
        start_prev <= o_start;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [6:0] a, input logic rw,
                            input logic [7:0] d);
        int n = 0;
        while (!o_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", o_cmd_ready, 1);
        i_cmd_addr = a;
        i_cmd_rw = rw;
        i_cmd_data = d;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!o_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", o_start, 1);
        seen_addr = o_Slave_Add;
    endtask

    task automatic master_xfer(input logic ack, input logic [7:0] rd);
        wait_start();
        i_busy = 1'b1;
        @(negedge clk);
        chk("start_drop", o_start, 0);
        repeat (2) @(negedge clk);
        i_done = 1'b1;
        i_ack_ok = ack;
        i_rd_data = rd;
        i_busy = 1'b0;
        @(negedge clk);
        i_done = 1'b0;
        i_ack_ok = 1'b0;
        i_rd_data = '0;
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] d,
                             input logic [1:0] st);
        int n = 0;
        while (!o_rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, o_rsp_valid, 1);
        chk({tag, "_data"}, o_rsp_data, d);
        chk({tag, "_status"}, o_rsp_status, st);
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        chk({tag, "_drop"}, o_rsp_valid, 0);
    endtask

    initial begin
        int s0;
        int n;
        logic seen;

        repeat (2) @(negedge clk);
        chk("rst_start", o_start, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_status", o_rsp_status, 0);
        chk("rst_addr", o_Slave_Add, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", o_cmd_ready, 1);

        // Write with latency check.
        push_cmd(7'h55, 1'b0, 8'h07);
        chk("lat_0", o_start, 0);
        @(negedge clk);
        chk("lat_1", o_start, 0);
        @(negedge clk);
        chk("lat_2", o_start, 1);
        chk("wr_addr", o_Slave_Add, 7'h55);
        chk("wr_data", o_DATA, 8'h07);
        chk("wr_rw", o_RW, 0);
        master_xfer(1'b1, 8'hAA);
        check_rsp("wr", 8'h00, 2'd0);

        // Read.
        push_cmd(7'h2A, 1'b1, 8'h00);
        wait_start();
        chk("rd_rw", o_RW, 1);
        chk("rd_addr", seen_addr, 7'h2A);
        master_xfer(1'b1, 8'hC3);
        check_rsp("rd", 8'hC3, 2'd0);

        // Three NACKs exhaust the retries.
        push_cmd(7'h11, 1'b0, 8'h22);
        s0 = start_cnt;
        repeat (3) master_xfer(1'b0, 8'h00);
        check_rsp("nack", 8'h00, 2'd1);
        repeat (5) @(negedge clk);
        chk("nack_starts", start_cnt - s0, 3);
        chk("nack_no_start", o_start, 0);

        // Two NACKs then ACK on a read.
        push_cmd(7'h12, 1'b1, 8'h00);
        s0 = start_cnt;
        master_xfer(1'b0, 8'h00);
        master_xfer(1'b0, 8'h00);
        master_xfer(1'b1, 8'h5A);
        check_rsp("retry_ok", 8'h5A, 2'd0);
        chk("retry_starts", start_cnt - s0, 3);

        // Reset in WAIT_DONE with a second command queued.
        push_cmd(7'h60, 1'b0, 8'h01);
        push_cmd(7'h61, 1'b0, 8'h02);
        wait_start();
        i_busy = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_start", o_start, 0);
        chk("mrst_rsp_valid", o_rsp_valid, 0);
        chk("mrst_rsp_data", o_rsp_data, 0);
        chk("mrst_status", o_rsp_status, 0);
        chk("mrst_addr", o_Slave_Add, 0);
        chk("mrst_rw", o_RW, 0);
        chk("mrst_data", o_DATA, 0);
        @(negedge clk);
        rst = 1'b0;
        i_busy = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_start || o_rsp_valid) seen = 1'b1;
        end
        chk("mrst_quiet", seen, 0);
        chk("mrst_ready", o_cmd_ready, 1);

        // Timeout, then the queued command runs normally.
        push_cmd(7'h33, 1'b0, 8'h44);
        push_cmd(7'h34, 1'b0, 8'h45);
        wait_start();
        chk("to_addr", seen_addr, 7'h33);
        i_busy = 1'b1;
        @(negedge clk);
        n = 0;
        while (!o_rsp_valid && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO);
        i_busy = 1'b0;
        check_rsp("to", 8'h00, 2'd2);
        master_xfer(1'b1, 8'h00);
        chk("to_next_addr", seen_addr, 7'h34);
        check_rsp("to_next", 8'h00, 2'd0);

        // Fill the FIFO while the master stalls in ISSUE.
        for (int i = 0; i < 5; i++) begin
            i_cmd_addr = 7'h40 + 7'(i);
            i_cmd_rw = (i == 0);
            i_cmd_data = 8'(i);
            i_cmd_valid = 1'b1;
            @(negedge clk);
        end
        i_cmd_valid = 1'b0;
        chk("full_ready", o_cmd_ready, 0);
        chk("full_start", o_start, 1);
        chk("full_addr", o_Slave_Add, 7'h40);
        master_xfer(1'b1, 8'h9E);
        n = 0;
        while (!o_rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_data !== 8'h9E ||
                o_rsp_status !== 2'd0 || o_start) seen = 1'b1;
        end
        chk("hold_stable", seen, 0);
        check_rsp("hold", 8'h9E, 2'd0);
        @(negedge clk);
        chk("drain_ready", o_cmd_ready, 1);
        for (int i = 1; i < 5; i++) begin
            master_xfer(1'b1, 8'h00);
            chk("drain_addr", seen_addr, 7'h40 + 7'(i));
            check_rsp("drain", 8'h00, 2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream command stage for the single-byte I2C master. It buffers up to DEPTH host commands in a FIFO. Each command is a 7-bit slave address, a R/W bit and a write byte. The block issues commands one at a time to the master over a start/busy/done handshake, retries NACKed transfers, and enforces a timeout. It returns one response per command: read data plus status.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
MAX_RETRY, 2, extra attempts after a NACK before reporting failure
TIMEOUT, 1024, clk cycles allowed from start acceptance to done

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
i_cmd_valid  input  1  host command present
o_cmd_ready  output  1  FIFO can accept (not full)
i_cmd_addr  input  7  slave address
i_cmd_rw  input  1  1=read, 0=write
i_cmd_data  input  8  write byte (ignored for reads)
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  host accepts response
o_rsp_data  output  8  read byte (0 for writes)
o_rsp_status  output  2  0=OK, 1=NACK after retries, 2=timeout
o_Slave_Add  output  7  to master
o_RW  output  1  to master
o_DATA  output  8  to master
o_start  output  1  request to master, level until accepted
i_busy  input  1  master transaction in progress
i_done  input  1  one-cycle pulse, transaction finished
i_ack_ok  input  1  valid with i_done, 1=all bytes ACKed
i_rd_data  input  8  valid with i_done

Behaviour:
- Reset (async, any state): FIFO empty; FSM=IDLE; retry and timeout counters 0; o_start=0; o_rsp_valid=0; o_rsp_data=0; o_rsp_status=0; master-side outputs 0; o_cmd_ready=1 after release.
- FIFO push: i_cmd_valid&&o_cmd_ready. Pop: the FSM leaves IDLE. Push and pop in the same cycle when full is illegal because ready=0. When full, push is blocked. When not full, simultaneous push/pop keeps the count. Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- FSM states:
  - IDLE: if FIFO not empty, latch head into a command register, pop, clear retry count -> ISSUE.
  - ISSUE: drive command registers on master outputs and set o_start=1. On i_busy=1 -> WAIT_DONE, o_start=0, timeout count=0.
  - WAIT_DONE: timeout counter increments each cycle.
    - On i_done with i_ack_ok=1 -> RESP, status 0, data=i_rd_data for reads, else 0.
    - On i_done with i_ack_ok=0: if retry<MAX_RETRY, increment retry -> ISSUE. Otherwise -> RESP, status 1, data 0.
    - If the counter reaches TIMEOUT-1 without i_done -> RESP, status 2, data 0.
    - If i_done and timeout coincide, i_done wins.
  - RESP: o_rsp_valid=1 with data and status held stable until i_rsp_ready. On the handshake cycle, go to IDLE and drop o_rsp_valid next cycle.
- The ISSUE state has no timeout; the master must eventually assert busy.
- Latency: with an idle master, o_start rises 2 cycles after the command push edge.
- Master outputs hold the current command from ISSUE through RESP.
- Only one command is outstanding; the FIFO keeps accepting during a transfer.
- i_done outside WAIT_DONE is ignored.

Decomposition:
- Shared package i2c_pkg holds:
  - status encodings ST_OK=2'd0, ST_NACK=2'd1, ST_TIMEOUT=2'd2;
  - FSM state encodings;
  - command-word width constant CMD_W=16 (addr, rw, data packed MSB to LSB).
- One sub-module, i2c_cmd_fifo: synchronous FIFO, width CMD_W, depth DEPTH, with push/pop/full/empty and async reset.

Test Plan:
- Write: push addr 7'h55, rw 0, data 8'h07. The bench model asserts busy, then done with ack_ok=1 -> o_Slave_Add=55, o_DATA=07, o_start 2 cycles after push; response status 0, data 00.
- Read: push addr 7'h2A, rw 1. The model returns i_rd_data=8'hC3 with ack_ok=1 -> response status 0, data C3.
- NACK retry: the model NACKs 3 times with MAX_RETRY=2 -> exactly 3 o_start assertions, then status 1. A variant NACKs twice then ACKs -> status 0.
- Timeout: the model asserts busy and never sends done -> status 2 exactly TIMEOUT cycles after busy seen. The next queued command then issues normally.
- Full/backpressure: push 5 commands back-to-back with the master stalled in ISSUE -> o_cmd_ready drops once the FIFO holds 4. Hold i_rsp_ready=0 for 10 cycles -> response stable, and no new o_start until accepted.
- Reset mid-transfer: assert rst in WAIT_DONE -> all outputs zero immediately (async). After release, o_cmd_ready=1, FIFO empty, and no response is emitted.
